// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: one outstanding req/gnt/rvalid access, PC ownership,
// redirect squashing and stall hold, with a registered IF/ID presentation.

module fetch_sequencer_checker (
    input logic        clk,
    input logic        rst,
    input logic        req,
    input logic        gnt,
    input logic        valid,
    input logic [31:0] addr
);

    a_no_req_while_presenting: assert property (@(posedge clk) disable iff (rst)
        !(req && valid));

    a_req_held_until_gnt: assert property (@(posedge clk) disable iff (rst)
        (req && !gnt) |=> (req && $stable(addr)));

    a_addr_word_aligned: assert property (@(posedge clk) disable iff (rst)
        addr[1:0] == 2'b00);

endmodule

module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] INST_NOP = 32'h0000_0013
) (
    input  logic        sys_clk_i,
    input  logic        rst_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_addr_i,
    input  logic        stall_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t      state_r, state_s;
    logic        req_r, req_s;
    logic [31:0] addr_r, addr_s;
    logic        valid_r, valid_s;
    logic [31:0] pc_r, pc_s;
    logic [31:0] inst_r, inst_s;
    logic        kill_r, kill_s;
    logic [31:0] target_r, target_s;
    logic [31:0] redir_pc_s;
    logic [31:0] seq_pc_s;

    assign redir_pc_s = redirect_addr_i & 32'hFFFF_FFFC;
    assign seq_pc_s   = pc_r + 32'd4;

    // State and registered outputs
    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r  <= S_IDLE;
            req_r    <= 1'b0;
            addr_r   <= RESET_PC;
            valid_r  <= 1'b0;
            pc_r     <= RESET_PC;
            inst_r   <= INST_NOP;
            kill_r   <= 1'b0;
            target_r <= RESET_PC;
        end else begin
            state_r  <= state_s;
            req_r    <= req_s;
            addr_r   <= addr_s;
            valid_r  <= valid_s;
            pc_r     <= pc_s;
            inst_r   <= inst_s;
            kill_r   <= kill_s;
            target_r <= target_s;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_s  = state_r;
        req_s    = req_r;
        addr_s   = addr_r;
        valid_s  = valid_r;
        pc_s     = pc_r;
        inst_s   = inst_r;
        kill_s   = kill_r;
        target_s = target_r;

        case (state_r)
            S_IDLE: begin
                req_s   = 1'b1;
                state_s = S_REQ;
                if (redirect_i) begin
                    target_s = redir_pc_s;
                    addr_s   = redir_pc_s;
                end else begin
                    addr_s = target_r;
                end
            end

            // The in-flight request is never withdrawn; a redirect only marks it dead.
            S_REQ: begin
                if (redirect_i) begin
                    kill_s   = 1'b1;
                    target_s = redir_pc_s;
                end else begin
                    kill_s = kill_r;
                end
                if (imem_gnt_i) begin
                    req_s   = 1'b0;
                    state_s = S_WAIT;
                end else begin
                    req_s = 1'b1;
                end
            end

            // A redirect arriving with the response counts as earlier, so it kills it.
            S_WAIT: begin
                if (redirect_i) begin
                    kill_s   = 1'b1;
                    target_s = redir_pc_s;
                end else begin
                    kill_s = kill_r;
                end
                if (imem_rvalid_i) begin
                    if (kill_r || redirect_i) begin
                        kill_s  = 1'b0;
                        req_s   = 1'b1;
                        addr_s  = redirect_i ? redir_pc_s : target_r;
                        state_s = S_REQ;
                    end else begin
                        inst_s  = imem_rdata_i;
                        pc_s    = addr_r;
                        valid_s = 1'b1;
                        state_s = S_OUT;
                    end
                end else begin
                    state_s = S_WAIT;
                end
            end

            S_OUT: begin
                if (redirect_i) begin
                    valid_s  = 1'b0;
                    inst_s   = INST_NOP;
                    req_s    = 1'b1;
                    addr_s   = redir_pc_s;
                    target_s = redir_pc_s;
                    state_s  = S_REQ;
                end else if (stall_i) begin
                    state_s = S_OUT;
                end else begin
                    valid_s  = 1'b0;
                    inst_s   = INST_NOP;
                    req_s    = 1'b1;
                    addr_s   = seq_pc_s;
                    target_s = seq_pc_s;
                    state_s  = S_REQ;
                end
            end

            default: begin
                state_s = S_IDLE;
                req_s   = 1'b0;
                valid_s = 1'b0;
                inst_s  = INST_NOP;
                kill_s  = 1'b0;
            end
        endcase
    end

    assign imem_req_o  = req_r;
    assign imem_addr_o = addr_r;
    assign if_valid_o  = valid_r;
    assign if_pc_o     = pc_r;
    assign if_inst_o   = inst_r;

    fetch_sequencer_checker u_checker (
        .clk   (sys_clk_i),
        .rst   (rst_i),
        .req   (req_r),
        .gnt   (imem_gnt_i),
        .valid (valid_r),
        .addr  (addr_r)
    );

endmodule
